// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   state_t    : FSM state encoding (IDLE, SHIFT, GAP, DONE)
//   frame_len  : bits per frame for a given pattern width (adds the parity bit when enabled)
//   cnt_width  : register width able to hold 0..max_val (never narrower than 1 bit)
// Optional feature macro: SERIAL_PATTERN_GEN_PARITY_EN (appends an even-parity bit to every frame).
package serial_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int w);
    return w + PARITY_BITS;
  endfunction

  // A zero-length gap still needs a legal 1-bit counter declaration.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_generator_piso.sv
// piso_shift_reg: W-bit parallel-load, MSB-first shift register.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (clears the register)
//   load       in   load load_data (takes priority over shift)
//   shift      in   shift left by one, zero fills the LSB
//   load_data  in   W-bit parallel load value
//   msb        out  current MSB of the register
module piso_shift_reg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         msb
);

  logic [W-1:0] bits_reg;
  logic [W-1:0] bits_next;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign bits_next[gi] = load ? load_data[gi] : (shift ? 1'b0 : bits_reg[gi]);
      end else begin : g_upper
        assign bits_next[gi] = load ? load_data[gi] : (shift ? bits_reg[gi-1] : bits_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_reg <= '0;
    end else begin
      bits_reg <= bits_next;
    end
  end

  assign msb = bits_reg[W-1];

endmodule

// File: rtl/serial_pattern_generator.sv
// serial_pattern_generator: accepts a pattern word over a valid/ready handshake and
// transmits it MSB-first, one bit per clock, repeated repeat_cnt+1 times with
// GAP_CYCLES idle cycles between frames.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   load_valid   in   pattern/repeat_cnt valid
//   load_ready   out  high in IDLE (and not in reset)
//   pattern      in   W-bit pattern, sent MSB first
//   repeat_cnt   in   extra repetitions (0 = send once)
//   dataout      out  registered serial data
//   bit_valid    out  dataout carries a frame bit
//   frame_start  out  high with the first bit of every frame
//   busy         out  state != IDLE
//   done         out  one-cycle pulse after the final bit of the final frame
// Optional feature macro: SERIAL_PATTERN_GEN_PARITY_EN appends an even-parity bit
// (XOR of the pattern) after the pattern bits of every frame.
module serial_pattern_generator
  import serial_pattern_gen_pkg::*;
#(
  parameter int W          = 3,
  parameter int RW         = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  pattern,
  input  logic [RW-1:0] repeat_cnt,
  output logic          dataout,
  output logic          bit_valid,
  output logic          frame_start,
  output logic          busy,
  output logic          done
);

  localparam int FL = frame_len(W);
  localparam int BW = cnt_width(FL);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(FL - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam logic [BW-1:0] PAR_IDX  = BW'(W - 1);
`endif

  state_t        state_reg;
  logic [BW-1:0] bit_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [RW-1:0] rep_cnt_reg;
  logic [W-1:0]  shadow_reg;

  logic          accept;
  logic          last_bit;
  logic          reps_left;
  logic          restart;
  logic          piso_load;
  logic          piso_shift;
  logic [W-1:0]  piso_data;
  logic          piso_msb;

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  logic          parity_bit;
  assign parity_bit = ^shadow_reg;
`endif

  assign accept    = load_valid && (state_reg == IDLE);
  assign last_bit  = (bit_cnt_reg == BIT_LAST);
  assign reps_left = (rep_cnt_reg != '0);

  // A new frame begins either straight after the last bit (no gap) or at the end of a gap.
  assign restart = ((state_reg == SHIFT) && last_bit && reps_left && NO_GAP) ||
                   ((state_reg == GAP) && (gap_cnt_reg == GAP_LAST));

  // The first bit of each frame goes straight to dataout, so the shift register is
  // loaded with the remaining bits already moved up to the MSB position.
  assign piso_load  = accept || restart;
  assign piso_shift = (state_reg == SHIFT) && !last_bit;
  assign piso_data  = accept ? {pattern[W-2:0], 1'b0} : {shadow_reg[W-2:0], 1'b0};

  piso_shift_reg #(
    .W(W)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (piso_load),
    .shift     (piso_shift),
    .load_data (piso_data),
    .msb       (piso_msb)
  );

  assign load_ready = (state_reg == IDLE) && !rst;
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      rep_cnt_reg <= '0;
      shadow_reg  <= '0;
      dataout     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      done        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shadow_reg  <= pattern;
            rep_cnt_reg <= repeat_cnt;
            bit_cnt_reg <= '0;
            dataout     <= pattern[W-1];
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            bit_valid   <= 1'b1;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            if (bit_cnt_reg == PAR_IDX) begin
              dataout <= parity_bit;
            end else begin
              dataout <= piso_msb;
            end
`else
            dataout     <= piso_msb;
`endif
          end else if (reps_left) begin
            rep_cnt_reg <= rep_cnt_reg - 1'b1;
            if (NO_GAP) begin
              bit_cnt_reg <= '0;
              dataout     <= shadow_reg[W-1];
              bit_valid   <= 1'b1;
              frame_start <= 1'b1;
            end else begin
              state_reg   <= GAP;
              gap_cnt_reg <= '0;
              dataout     <= 1'b0;
              bit_valid   <= 1'b0;
            end
          end else begin
            state_reg <= DONE;
            done      <= 1'b1;
            dataout   <= 1'b0;
            bit_valid <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
            dataout     <= shadow_reg[W-1];
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed, table-driven bench for serial_pattern_generator.
// Two instances: dut (default GAP_CYCLES=2) and dut0 (GAP_CYCLES=0).
// Each table row lists, per cycle after the accept edge, the expected
// dataout / bit_valid / frame_start / done / busy as character strings.
module tb_serial_pattern_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lv0, lv1;
  logic [2:0] pat0, pat1;
  logic [3:0] rc0, rc1;
  logic       lr0, d0, bv0, fs0, b0, dn0;
  logic       lr1, d1, bv1, fs1, b1, dn1;
  logic [5:0] obs0, obs1;

  assign obs0 = {lr0, b0, dn0, fs0, bv0, d0};
  assign obs1 = {lr1, b1, dn1, fs1, bv1, d1};

  serial_pattern_generator #(.W(3), .RW(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(lr0), .pattern(pat0),
    .repeat_cnt(rc0), .dataout(d0), .bit_valid(bv0), .frame_start(fs0),
    .busy(b0), .done(dn0)
  );

  serial_pattern_generator #(.W(3), .RW(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(lr1), .pattern(pat1),
    .repeat_cnt(rc1), .dataout(d1), .bit_valid(bv1), .frame_start(fs1),
    .busy(b1), .done(dn1)
  );

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         sel;      // 0: dut, 1: dut0
    bit         hold;     // keep load_valid high and switch pattern after accept
    logic [2:0] pattern;
    logic [3:0] rep;
    logic [2:0] hold_pattern;
    string      d, v, fs, dn, bz;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input bit sel, input bit hold, input logic [2:0] p,
                              input logic [3:0] r, input logic [2:0] hp,
                              input string d, input string v, input string fs,
                              input string dn, input string bz);
    vec_t t;
    t.sel = sel; t.hold = hold; t.pattern = p; t.rep = r; t.hold_pattern = hp;
    t.d = d; t.v = v; t.fs = fs; t.dn = dn; t.bz = bz;
    return t;
  endfunction

  function automatic bit ch(input string s, input int i);
    return (s[i] == "1");
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (ready,busy,done,fs,valid,data)", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_load(input bit sel, input logic v, input logic [2:0] p, input logic [3:0] r);
    if (sel) begin lv1 = v; pat1 = p; rc1 = r; end
    else begin lv0 = v; pat0 = p; rc0 = r; end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int n;
    bit pend;
    logic [5:0] exp;
    n = t.d.len();
    pend = 1'b0;
    @(posedge clk); #1;
    drive_load(t.sel, 1'b1, t.pattern, t.rep);
    @(posedge clk); #1;                  // accept edge = cycle 0
    if (t.hold) drive_load(t.sel, 1'b1, t.hold_pattern, t.rep);
    else        drive_load(t.sel, 1'b0, t.pattern, t.rep);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp = {!ch(t.bz, i), ch(t.bz, i), ch(t.dn, i), ch(t.fs, i), ch(t.v, i), ch(t.d, i)};
      chk($sformatf("vec%0d_cyc%0d", idx, i + 1), t.sel ? obs1 : obs0, exp);
      // In hold mode load_valid drops once the held pattern has been accepted from IDLE.
      if (pend) begin
        drive_load(t.sel, 1'b0, t.hold_pattern, t.rep);
        pend = 1'b0;
      end else if (t.hold && !ch(t.bz, i) && (t.sel ? lv1 : lv0)) begin
        pend = 1'b1;
      end
    end
    lv0 = 1'b0;
    lv1 = 1'b0;
    $display("vec %0d: sel=%0d pattern=%b repeat=%0d hold=%0d cycles=%0d", idx, t.sel, t.pattern, t.rep, t.hold, n);
  endtask

  initial begin
    int fsc, vc;
    bit seen;

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    vecs[0] = mk(0, 0, 3'b101, 4'd0, 3'b000, "101000", "111100", "100000", "000010", "111110");
    vecs[1] = mk(0, 0, 3'b111, 4'd0, 3'b000, "111100", "111100", "100000", "000010", "111110");
    vecs[2] = mk(0, 0, 3'b110, 4'd1, 3'b000, "110000110000", "111100111100", "100000100000",
                 "000000000010", "111111111110");
    vecs[3] = mk(0, 0, 3'b011, 4'd0, 3'b000, "011000", "111100", "100000", "000010", "111110");
    vecs[4] = mk(1, 0, 3'b101, 4'd1, 3'b000, "1010101000", "1111111100", "1000100000",
                 "0000000010", "1111111110");
    vecs[5] = mk(0, 1, 3'b101, 4'd0, 3'b011, "101000011000", "111100111100", "100000100000",
                 "000010000010", "111110111110");
`else
    vecs[0] = mk(0, 0, 3'b101, 4'd0, 3'b000, "10100", "11100", "10000", "00010", "11110");
    vecs[1] = mk(0, 0, 3'b110, 4'd2, 3'b000, "110001100011000", "111001110011100",
                 "100001000010000", "000000000000010", "111111111111110");
    vecs[2] = mk(0, 0, 3'b011, 4'd1, 3'b000, "0110001100", "1110011100", "1000010000",
                 "0000000010", "1111111110");
    vecs[3] = mk(0, 0, 3'b100, 4'd0, 3'b000, "10000", "11100", "10000", "00010", "11110");
    vecs[4] = mk(1, 0, 3'b101, 4'd1, 3'b000, "10110100", "11111100", "10010000",
                 "00000010", "11111110");
    vecs[5] = mk(0, 1, 3'b101, 4'd0, 3'b011, "1010001100", "1110011100", "1000010000",
                 "0001000010", "1111011110");
`endif

    rst = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0;
    pat0 = '0; pat1 = '0; rc0 = '0; rc1 = '0;

    // Reset state: everything low, load_ready held low by rst.
    #3;
    chk("reset_dut", obs0, 6'b000000);
    chk("reset_dut0", obs1, 6'b000000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_dut", obs0, 6'b100000);
    chk("idle_dut0", obs1, 6'b100000);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Reset asserted between edges mid-frame: outputs fall at once, no done afterwards.
    @(posedge clk); #1;
    drive_load(0, 1'b1, 3'b111, 4'd0);
    @(posedge clk); #1;
    drive_load(0, 1'b0, 3'b111, 4'd0);
    @(negedge clk);
    chk("rst_seq_cyc1", obs0, 6'b010111);
    @(negedge clk);
    chk("rst_seq_cyc2", obs0, 6'b010011);
    #2 rst = 1'b1;
    #1;
    chk("rst_seq_async", obs0, 6'b000000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_seq_after%0d", i), obs0, 6'b100000);
    end
    $display("rst mid-frame sequence complete");

    // Maximum repeat count with no gap: 16 back-to-back frames.
    @(posedge clk); #1;
    drive_load(1, 1'b1, 3'b110, 4'hF);
    @(posedge clk); #1;
    drive_load(1, 1'b0, 3'b110, 4'hF);
    fsc = 0; vc = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fs1) fsc++;
      if (bv1) vc++;
      if (dn1) begin
        seen = 1'b1;
        break;
      end
    end
    chk_int("repmax_done_seen", int'(seen), 1);
    chk_int("repmax_frames", fsc, 16);
    chk_int("repmax_bits", vc, 16 * FL);
    @(negedge clk);
    chk("repmax_back_idle", obs1, 6'b100000);
    $display("repeat-max sequence: frames=%0d bits=%0d", fsc, vc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
